// File: rtl/dram_cmd_issue.sv
// dram_cmd_issue: pops requests from a show-ahead FIFO and drives ACT/PRE/RD/WR (and REF) on registered DRAM pins.
// Latency: a row hit reaches the pins 2 cycles after the pop; a closed bank adds ACT + T_RCD; a row miss adds PRE + T_RP first.
// Backpressure: pops only in IDLE with no refresh pending; one request in flight, so the next pop comes no earlier than its RD/WR cycle.
//
// Ports: clk/rst (synchronous, active-low); req_empty/req_data/req_read_en = FIFO head {we,bank,row,col} and pop strobe;
//        ref_req/ref_ack = refresh level request and done pulse; dram_* = registered command pins, bank and address;
//        rd_issue/wr_issue = pulses aligned with the RD/WR command on the pins; busy = FSM not in IDLE.
// Build option: define DRAM_CMD_ISSUE_REFRESH_EN to include the refresh path (PREALL/REF sequence). Without it,
//        ref_req is ignored and ref_ack is tied low.
module dram_cmd_issue #(
    parameter int BANK_W = 2,
    parameter int ROW_W  = 13,
    parameter int COL_W  = 10,
    parameter int ADDR_W = 13,
    parameter int T_RCD  = 3,
    parameter int T_RP   = 3,
    parameter int T_RFC  = 8,
    parameter int CNT_W  = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            req_empty,
    input  logic [BANK_W+ROW_W+COL_W:0]     req_data,
    output logic                            req_read_en,
    input  logic                            ref_req,
    output logic                            ref_ack,
    output logic                            dram_cs_n,
    output logic                            dram_ras_n,
    output logic                            dram_cas_n,
    output logic                            dram_we_n,
    output logic [BANK_W-1:0]               dram_ba,
    output logic [ADDR_W-1:0]               dram_addr,
    output logic                            rd_issue,
    output logic                            wr_issue,
    output logic                            busy
);

    localparam int NB = 1 << BANK_W;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_RD  = 4'b0101;
    localparam logic [3:0] CMD_WR  = 4'b0100;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_DES = 4'b1111;

    localparam logic [CNT_W-1:0] LD_RCD = CNT_W'(T_RCD - 1);
    localparam logic [CNT_W-1:0] LD_RP  = CNT_W'(T_RP - 1);
`ifdef DRAM_CMD_ISSUE_REFRESH_EN
    localparam logic [3:0]       CMD_REF = 4'b0001;
    localparam logic [CNT_W-1:0] LD_RFC  = CNT_W'(T_RFC - 1);
`endif

    // Reject parameter sets the address/timer logic cannot represent.
    if (COL_W > 10 || ADDR_W < 11 || ADDR_W < ROW_W ||
        T_RCD < 1 || T_RCD >= (1 << CNT_W) ||
        T_RP  < 1 || T_RP  >= (1 << CNT_W) ||
        T_RFC < 1 || T_RFC >= (1 << CNT_W)) begin : g_bad_param
        $error("dram_cmd_issue: illegal parameter combination");
    end

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        PRE      = 4'd1,
        WAIT_RP  = 4'd2,
        ACT      = 4'd3,
        WAIT_RCD = 4'd4,
        RDWR     = 4'd5
`ifdef DRAM_CMD_ISSUE_REFRESH_EN
        ,
        PREALL   = 4'd6,
        WAIT_RPA = 4'd7,
        REF      = 4'd8,
        WAIT_RFC = 4'd9
`endif
    } state_t;

    state_t                      state, state_nxt;
    logic [CNT_W-1:0]            tmr, tmr_nxt;
    logic [BANK_W+ROW_W+COL_W:0] req_q;
    logic [NB-1:0]               row_vld;
    logic [ROW_W-1:0]            row_tab [NB];
    logic [3:0]                  cmd_q, cmd_nxt;
    logic [BANK_W-1:0]           ba_nxt;
    logic [ADDR_W-1:0]           addr_nxt;
    logic                        rd_nxt, wr_nxt;
    logic                        ref_pending;

    // Head-of-FIFO fields, used for the decode in the pop cycle.
    logic [BANK_W-1:0] in_bank;
    logic [ROW_W-1:0]  in_row;
    assign in_bank = req_data[ROW_W+COL_W +: BANK_W];
    assign in_row  = req_data[COL_W +: ROW_W];

    // Latched request fields, used by every command state after the pop.
    logic              q_we;
    logic [BANK_W-1:0] q_bank;
    logic [ROW_W-1:0]  q_row;
    logic [COL_W-1:0]  q_col;
    assign q_we   = req_q[BANK_W+ROW_W+COL_W];
    assign q_bank = req_q[ROW_W+COL_W +: BANK_W];
    assign q_row  = req_q[COL_W +: ROW_W];
    assign q_col  = req_q[COL_W-1:0];

    assign req_read_en = rst & (state == IDLE) & ~req_empty & ~ref_pending;
    assign busy        = (state != IDLE);
    assign {dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n} = cmd_q;

`ifdef DRAM_CMD_ISSUE_REFRESH_EN
    logic ack_nxt;
    logic ref_pend_q;
    // ref_req seen in IDLE blocks the pop in that very cycle, not just from the next one.
    assign ref_pending = ref_pend_q | (ref_req & (state == IDLE));

    always_ff @(posedge clk) begin
        if (!rst) begin
            ref_pend_q <= 1'b0;
            ref_ack    <= 1'b0;
        end else begin
            ref_ack <= ack_nxt;
            if (ack_nxt) begin
                ref_pend_q <= 1'b0;
            end else if (state == IDLE && ref_req) begin
                ref_pend_q <= 1'b1;
            end
        end
    end
`else
    logic unused_ref;
    assign unused_ref  = ref_req;
    assign ref_pending = 1'b0;
    assign ref_ack     = 1'b0;
`endif

    // Wait states leave when the timer is about to reach 0, so the following
    // command lands on the pins exactly T_* cycles after the previous one.
    always_comb begin
        state_nxt = state;
        tmr_nxt   = (tmr != '0) ? tmr - CNT_W'(1) : '0;
        cmd_nxt   = CMD_NOP;
        ba_nxt    = dram_ba;
        addr_nxt  = dram_addr;
        rd_nxt    = 1'b0;
        wr_nxt    = 1'b0;
`ifdef DRAM_CMD_ISSUE_REFRESH_EN
        ack_nxt   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (req_read_en) begin
                    if (row_vld[in_bank] && row_tab[in_bank] == in_row) begin
                        state_nxt = RDWR;
                    end else if (row_vld[in_bank]) begin
                        state_nxt = PRE;
                    end else begin
                        state_nxt = ACT;
                    end
                end
`ifdef DRAM_CMD_ISSUE_REFRESH_EN
                else if (ref_pending) begin
                    state_nxt = PREALL;
                end
`endif
            end
            PRE: begin
                cmd_nxt   = CMD_PRE;
                ba_nxt    = q_bank;
                addr_nxt  = '0;
                tmr_nxt   = LD_RP;
                state_nxt = WAIT_RP;
            end
            WAIT_RP: begin
                if (tmr <= CNT_W'(1)) state_nxt = ACT;
            end
            ACT: begin
                cmd_nxt                = CMD_ACT;
                ba_nxt                 = q_bank;
                addr_nxt               = '0;
                addr_nxt[ROW_W-1:0]    = q_row;
                tmr_nxt                = LD_RCD;
                state_nxt              = WAIT_RCD;
            end
            WAIT_RCD: begin
                if (tmr <= CNT_W'(1)) state_nxt = RDWR;
            end
            RDWR: begin
                cmd_nxt                = q_we ? CMD_WR : CMD_RD;
                ba_nxt                 = q_bank;
                addr_nxt               = '0;
                addr_nxt[COL_W-1:0]    = q_col;
                rd_nxt                 = ~q_we;
                wr_nxt                 = q_we;
                state_nxt              = IDLE;
            end
`ifdef DRAM_CMD_ISSUE_REFRESH_EN
            PREALL: begin
                // Issued unconditionally, whether or not any bank is open.
                cmd_nxt      = CMD_PRE;
                addr_nxt     = '0;
                addr_nxt[10] = 1'b1;
                tmr_nxt      = LD_RP;
                state_nxt    = WAIT_RPA;
            end
            WAIT_RPA: begin
                if (tmr <= CNT_W'(1)) state_nxt = REF;
            end
            REF: begin
                cmd_nxt   = CMD_REF;
                tmr_nxt   = LD_RFC;
                state_nxt = WAIT_RFC;
            end
            WAIT_RFC: begin
                if (tmr == '0) begin
                    ack_nxt   = 1'b1;
                    state_nxt = IDLE;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            tmr       <= '0;
            req_q     <= '0;
            row_vld   <= '0;
            cmd_q     <= CMD_DES;
            dram_ba   <= '0;
            dram_addr <= '0;
            rd_issue  <= 1'b0;
            wr_issue  <= 1'b0;
        end else begin
            state     <= state_nxt;
            tmr       <= tmr_nxt;
            cmd_q     <= cmd_nxt;
            dram_ba   <= ba_nxt;
            dram_addr <= addr_nxt;
            rd_issue  <= rd_nxt;
            wr_issue  <= wr_nxt;
            if (req_read_en) req_q <= req_data;
            if (state == PRE) begin
                row_vld[q_bank] <= 1'b0;
            end else if (state == ACT) begin
                row_vld[q_bank] <= 1'b1;
            end
`ifdef DRAM_CMD_ISSUE_REFRESH_EN
            else if (state == PREALL) begin
                row_vld <= '0;
            end
`endif
        end
    end

    // Row contents only matter while the matching valid bit is set.
    always_ff @(posedge clk) begin
        if (state == ACT) row_tab[q_bank] <= q_row;
    end

endmodule

// File: tb/tb_dram_cmd_issue.sv
module tb_dram_cmd_issue;

    localparam logic [3:0] C_NOP = 4'b0111;
    localparam logic [3:0] C_ACT = 4'b0011;
    localparam logic [3:0] C_RD  = 4'b0101;
    localparam logic [3:0] C_WR  = 4'b0100;
    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_DES = 4'b1111;
`ifdef DRAM_CMD_ISSUE_REFRESH_EN
    localparam logic [3:0] C_REF = 4'b0001;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_empty;
    logic [25:0] req_data;
    logic        req_read_en;
    logic        ref_req;
    logic        ref_ack;
    logic        dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n;
    logic [1:0]  dram_ba;
    logic [12:0] dram_addr;
    logic        rd_issue, wr_issue, busy;

    always #5 clk = ~clk;

    dram_cmd_issue dut (
        .clk         (clk),
        .rst         (rst),
        .req_empty   (req_empty),
        .req_data    (req_data),
        .req_read_en (req_read_en),
        .ref_req     (ref_req),
        .ref_ack     (ref_ack),
        .dram_cs_n   (dram_cs_n),
        .dram_ras_n  (dram_ras_n),
        .dram_cas_n  (dram_cas_n),
        .dram_we_n   (dram_we_n),
        .dram_ba     (dram_ba),
        .dram_addr   (dram_addr),
        .rd_issue    (rd_issue),
        .wr_issue    (wr_issue),
        .busy        (busy)
    );

    typedef struct packed {
        logic [3:0]  cmd;
        logic [1:0]  ba;
        logic [12:0] addr;
        logic        rd;
        logic        wr;
        int          cyc;
    } ev_t;

    ev_t cmd_log[$];
    int  pop_log[$];
    int  ack_log[$];
    int  cyc = 0;
    int  bad_pop = 0;
    int  stray = 0;
    int  n_cmp = 0;
    int  n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Passive monitor: records every non-NOP command, pop and ack with its cycle.
    always @(negedge clk) begin
        ev_t e;
        e.cmd  = {dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n};
        e.ba   = dram_ba;
        e.addr = dram_addr;
        e.rd   = rd_issue;
        e.wr   = wr_issue;
        e.cyc  = cyc;
        if (e.cmd != C_NOP && e.cmd != C_DES) cmd_log.push_back(e);
        if (req_read_en) pop_log.push_back(cyc);
        if (ref_ack) ack_log.push_back(cyc);
        if (req_read_en && req_empty) bad_pop <= bad_pop + 1;
        if ((rd_issue && e.cmd != C_RD) || (wr_issue && e.cmd != C_WR)) stray <= stray + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic ev_t ev_at(input int i);
        ev_t e;
        e = '0;
        e.cmd = 4'hE;
        e.cyc = -9999;
        if (i < cmd_log.size()) e = cmd_log[i];
        return e;
    endfunction

    function automatic int pop_at(input int i);
        return (i < pop_log.size()) ? pop_log[i] : -9999;
    endfunction

    function automatic int ack_at(input int i);
        return (i < ack_log.size()) ? ack_log[i] : -9999;
    endfunction

    task automatic clear_logs();
        cmd_log.delete();
        pop_log.delete();
        ack_log.delete();
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for the pop strobe, then empties the FIFO right after the pop edge.
    task automatic wait_pop(input string tag);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (req_read_en) got = 1'b1;
        end
        @(posedge clk);
        #1;
        req_empty = 1'b1;
        chk({tag, "_pop_seen"}, 32'(got), 32'd1);
    endtask

    task automatic issue_req(input string tag, input logic we, input logic [1:0] ba,
                             input logic [12:0] row, input logic [9:0] col);
        req_data  = {we, ba, row, col};
        req_empty = 1'b0;
        wait_pop(tag);
    endtask

    initial begin
        ev_t e0, e1, e2, e3;
        int  n_busy;

        rst       = 1'b0;
        req_empty = 1'b0;
        req_data  = 26'h3FF_FFFF;
        ref_req   = 1'b0;
        step(3);

        // Reset state, with a non-empty FIFO presented during reset.
        @(negedge clk);
        chk("rst_pins",    32'({dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n}), 32'(C_DES));
        chk("rst_ba",      32'(dram_ba), 32'd0);
        chk("rst_addr",    32'(dram_addr), 32'd0);
        chk("rst_busy",    32'(busy), 32'd0);
        chk("rst_rd",      32'(rd_issue), 32'd0);
        chk("rst_wr",      32'(wr_issue), 32'd0);
        chk("rst_ack",     32'(ref_ack), 32'd0);
        chk("rst_read_en", 32'(req_read_en), 32'd0);
        @(posedge clk);
        #1;
        rst       = 1'b1;
        req_empty = 1'b1;
        step(3);
        @(negedge clk);
        chk("idle_nop", 32'({dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n}), 32'(C_NOP));
        step(1);

        // Closed bank: ACT then RD exactly T_RCD later.
        clear_logs();
        issue_req("t1", 1'b0, 2'd1, 13'h005, 10'h010);
        step(8);
        e0 = ev_at(0);
        e1 = ev_at(1);
        chk("t1_ncmd",     32'(cmd_log.size()), 32'd2);
        chk("t1_act",      32'(e0.cmd), 32'(C_ACT));
        chk("t1_act_ba",   32'(e0.ba), 32'd1);
        chk("t1_act_addr", 32'(e0.addr), 32'h005);
        chk("t1_act_lat",  32'(e0.cyc - pop_at(0)), 32'd2);
        chk("t1_rd",       32'(e1.cmd), 32'(C_RD));
        chk("t1_rd_ba",    32'(e1.ba), 32'd1);
        chk("t1_rd_addr",  32'(e1.addr), 32'h010);
        chk("t1_trcd",     32'(e1.cyc - e0.cyc), 32'd3);
        chk("t1_rd_pulse", 32'(e1.rd), 32'd1);
        chk("t1_no_wr",    32'(e1.wr), 32'd0);

        // Row hit: WR two cycles after the pop, nothing else.
        clear_logs();
        issue_req("t2", 1'b1, 2'd1, 13'h005, 10'h020);
        step(6);
        e0 = ev_at(0);
        chk("t2_ncmd",     32'(cmd_log.size()), 32'd1);
        chk("t2_wr",       32'(e0.cmd), 32'(C_WR));
        chk("t2_wr_ba",    32'(e0.ba), 32'd1);
        chk("t2_wr_addr",  32'(e0.addr), 32'h020);
        chk("t2_lat",      32'(e0.cyc - pop_at(0)), 32'd2);
        chk("t2_wr_pulse", 32'(e0.wr), 32'd1);

        // Row miss: PRE, ACT T_RP later, RD T_RCD later.
        clear_logs();
        issue_req("t3", 1'b0, 2'd1, 13'h006, 10'h000);
        step(12);
        e0 = ev_at(0);
        e1 = ev_at(1);
        e2 = ev_at(2);
        chk("t3_ncmd",    32'(cmd_log.size()), 32'd3);
        chk("t3_pre",     32'(e0.cmd), 32'(C_PRE));
        chk("t3_pre_ba",  32'(e0.ba), 32'd1);
        chk("t3_pre_a10", 32'(e0.addr[10]), 32'd0);
        chk("t3_pre_lat", 32'(e0.cyc - pop_at(0)), 32'd2);
        chk("t3_act",     32'(e1.cmd), 32'(C_ACT));
        chk("t3_act_row", 32'(e1.addr), 32'h006);
        chk("t3_trp",     32'(e1.cyc - e0.cyc), 32'd3);
        chk("t3_rd",      32'(e2.cmd), 32'(C_RD));
        chk("t3_trcd",    32'(e2.cyc - e1.cyc), 32'd3);

        // Back-to-back hits: second pop lands in the first command's cycle.
        clear_logs();
        issue_req("t4a", 1'b1, 2'd1, 13'h006, 10'h3FF);
        issue_req("t4b", 1'b0, 2'd1, 13'h006, 10'h155);
        step(6);
        e0 = ev_at(0);
        e1 = ev_at(1);
        chk("t4_pop_gap", 32'(pop_at(1) - pop_at(0)), 32'd2);
        chk("t4_ncmd",    32'(cmd_log.size()), 32'd2);
        chk("t4_wr",      32'(e0.cmd), 32'(C_WR));
        chk("t4_wr_addr", 32'(e0.addr), 32'h3FF);
        chk("t4_rd",      32'(e1.cmd), 32'(C_RD));
        chk("t4_rd_addr", 32'(e1.addr), 32'h155);
        chk("t4_rd_lat",  32'(e1.cyc - pop_at(1)), 32'd2);

        // Empty FIFO for 20 cycles: no pops, no commands, never busy.
        clear_logs();
        n_busy = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy) n_busy++;
        end
        step(1);
        chk("t6_no_cmd",  32'(cmd_log.size()), 32'd0);
        chk("t6_no_pop",  32'(pop_log.size()), 32'd0);
        chk("t6_no_busy", 32'(n_busy), 32'd0);

        // Reset while waiting on T_RCD abandons the request and clears the row table.
        clear_logs();
        issue_req("t5", 1'b0, 2'd2, 13'h1AB, 10'h007);
        step(1);
        @(negedge clk);
        chk("t5_busy_mid", 32'(busy), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        chk("t5_rst_pins", 32'({dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n}), 32'(C_DES));
        chk("t5_rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(6);
        chk("t5_only_act", 32'(cmd_log.size()), 32'd1);
        clear_logs();
        issue_req("t5b", 1'b0, 2'd2, 13'h1AB, 10'h007);
        step(8);
        e0 = ev_at(0);
        e1 = ev_at(1);
        chk("t5_reopen",   32'(e0.cmd), 32'(C_ACT));
        chk("t5_act_row",  32'(e0.addr), 32'h1AB);
        chk("t5_rd",       32'(e1.cmd), 32'(C_RD));
        chk("t5_rd_addr",  32'(e1.addr), 32'h007);

`ifdef DRAM_CMD_ISSUE_REFRESH_EN
        // Refresh beats a waiting request; the request then has to re-ACT.
        clear_logs();
        req_data  = {1'b0, 2'd2, 13'h1AB, 10'h000};
        req_empty = 1'b0;
        ref_req   = 1'b1;
        repeat (3) @(negedge clk);
        ref_req = 1'b0;
        wait_pop("tr");
        step(8);
        e0 = ev_at(0);
        e1 = ev_at(1);
        e2 = ev_at(2);
        e3 = ev_at(3);
        chk("tr_npop",    32'(pop_log.size()), 32'd1);
        chk("tr_preall",  32'(e0.cmd), 32'(C_PRE));
        chk("tr_pre_a10", 32'(e0.addr[10]), 32'd1);
        chk("tr_ref",     32'(e1.cmd), 32'(C_REF));
        chk("tr_ref_gap", 32'(e1.cyc - e0.cyc), 32'd3);
        chk("tr_nack",    32'(ack_log.size()), 32'd1);
        chk("tr_ack_gap", 32'(ack_at(0) - e1.cyc), 32'd8);
        chk("tr_pop_ack", 32'(pop_at(0) - ack_at(0)), 32'd0);
        chk("tr_react",   32'(e2.cmd), 32'(C_ACT));
        chk("tr_act_row", 32'(e2.addr), 32'h1AB);
        chk("tr_rd",      32'(e3.cmd), 32'(C_RD));
`endif

        chk("bad_pop",     32'(bad_pop), 32'd0);
        chk("stray_issue", 32'(stray), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
